// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART-to-LED-matrix frame loader.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    HUNT0   = 2'd0,
    HUNT1   = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_e;

  // 32x32 pixels, 3 colour bytes each
  localparam int         FRAME_BYTES_DEF  = 32 * 32 * 3;
  localparam int         ADDR_W_DEF       = 12;
  localparam int         TIMEOUT_CLKS_DEF = 50000;
  localparam logic [7:0] SYNC0_DEF        = 8'hA5;
  localparam logic [7:0] SYNC1_DEF        = 8'h5A;

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the receiver's level-style done flag into a one-clock byte strobe and
// watches for an over-long gap between bytes while a frame is in progress.
module rx_byte_strobe #(
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic i_clk,
  input  logic rst_n,
  input  logic i_rx_done,
  input  logic i_count_en,
  output logic o_stb,
  output logic o_timeout
);

  localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic             rx_done_q, rx_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign rx_done_d = i_rx_done;
  assign o_stb     = i_rx_done & ~rx_done_q;
  // A byte arriving on the expiry clock still counts, so it suppresses the timeout.
  assign o_timeout = i_count_en & ~o_stb & (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (o_stb || !i_count_en || o_timeout) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rx_done_q <= rx_done_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Hunts a sync header in the UART byte stream, loads one image into the back
// buffer, verifies its checksum and swaps buffers on a display frame boundary.
module uart_frame_loader
  import uart_frame_pkg::*;
#(
  parameter int         FRAME_BYTES  = FRAME_BYTES_DEF,
  parameter int         ADDR_W       = ADDR_W_DEF,
  parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
  parameter logic [7:0] SYNC0        = SYNC0_DEF,
  parameter logic [7:0] SYNC1        = SYNC1_DEF
) (
  input  logic              i_clk,
  input  logic              rst_n,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_done,
  input  logic              i_frame_start,
  output logic              o_wr_en,
  output logic [ADDR_W:0]   o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_disp_buf,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic [7:0]        o_err_cnt,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(FRAME_BYTES - 1);

  logic stb, timeout;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic              swap_q, swap_d;
  logic              disp_q, disp_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              busy_q, busy_d;

  rx_byte_strobe #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_strobe (
    .i_clk     (i_clk),
    .rst_n     (rst_n),
    .i_rx_done (i_rx_done),
    .i_count_en(state_q != HUNT0),
    .o_stb     (stb),
    .o_timeout (timeout)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    swap_d    = swap_q;
    disp_d    = disp_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    // Only a swap that was already pending before this clock may complete now.
    if (swap_q && i_frame_start) begin
      swap_d = 1'b0;
      disp_d = ~disp_q;
      done_d = 1'b1;
    end

    if (timeout) begin
      state_d = HUNT0;
      err_d   = 1'b1;
    end else if (stb && !swap_q) begin
      unique case (state_q)
        HUNT0: begin
          if (i_rx_byte == SYNC0) state_d = HUNT1;
        end
        HUNT1: begin
          if (i_rx_byte == SYNC1) begin
            state_d = PAYLOAD;
            idx_d   = '0;
            sum_d   = '0;
          end else if (i_rx_byte != SYNC0) begin
            state_d = HUNT0;
          end
        end
        PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~disp_q, idx_q};
          wr_data_d = i_rx_byte;
          sum_d     = sum_q + i_rx_byte;
          if (idx_q == IDX_LAST) begin
            state_d = CHECK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        CHECK: begin
          state_d = HUNT0;
          if (i_rx_byte == sum_q) swap_d = 1'b1;
          else                    err_d  = 1'b1;
        end
        default: state_d = HUNT0;
      endcase
    end

    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 1'b1;

    busy_d = (state_d == PAYLOAD) || (state_d == CHECK) || swap_d;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT0;
      idx_q     <= '0;
      sum_q     <= '0;
      swap_q    <= 1'b0;
      disp_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      swap_q    <= swap_d;
      disp_q    <= disp_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_disp_buf   = disp_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader using a reduced frame size and timeout.
module tb_uart_frame_loader;

  localparam int FB = 12;
  localparam int AW = 4;
  localparam int TO = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_done = 1'b0;
  logic          frame_start = 1'b0;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [7:0]    wr_data;
  logic          disp_buf;
  logic          frame_done;
  logic          frame_err;
  logic [7:0]    err_cnt;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int wq[$];
  int done_n = 0;
  int err_n  = 0;
  int exp_done = 0;
  int exp_err  = 0;

  uart_frame_loader #(
    .FRAME_BYTES (FB),
    .ADDR_W      (AW),
    .TIMEOUT_CLKS(TO),
    .SYNC0       (8'hA5),
    .SYNC1       (8'h5A)
  ) dut (
    .i_clk        (clk),
    .rst_n        (rst_n),
    .i_rx_byte    (rx_byte),
    .i_rx_done    (rx_done),
    .i_frame_start(frame_start),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_disp_buf   (disp_buf),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_err_cnt    (err_cnt),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wq.push_back((int'(wr_addr) << 8) | int'(wr_data));
    if (frame_done) done_n++;
    if (frame_err) err_n++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs);
    rx_byte = b;
    rx_done = 1'b1;
    frame_start = fs;
    @(negedge clk);
    rx_done = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input int base, input int cs_delta, input logic fs_last);
    int s;
    s = 0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    for (int k = 0; k < FB; k++) begin
      send_byte(8'((base + k) & 255), 1'b0);
      s = s + ((base + k) & 255);
    end
    send_byte(8'((s + cs_delta) & 255), fs_last);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int base, input int bufsel);
    int n;
    check_val({tag, "_nwr"}, wq.size(), FB);
    n = (wq.size() < FB) ? wq.size() : FB;
    for (int k = 0; k < n; k++)
      check_val({tag, "_wr"}, wq[k], (((bufsel << AW) | k) << 8) | ((base + k) & 255));
    wq.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_wr_en", int'(wr_en), 0);
    check_val("rst_disp", int'(disp_buf), 0);
    check_val("rst_done", int'(frame_done), 0);
    check_val("rst_err", int'(frame_err), 0);
    check_val("rst_errcnt", int'(err_cnt), 0);
    check_val("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // valid frame into buffer 1, swap on frame start
    send_frame(0, 0, 1'b0);
    check_frame("t1", 0, 1);
    check_val("t1_busy_pend", int'(busy), 1);
    check_val("t1_disp_pre", int'(disp_buf), 0);
    check_val("t1_done_pre", done_n, exp_done);
    pulse_fs();
    exp_done++;
    check_val("t1_disp", int'(disp_buf), 1);
    check_val("t1_done", done_n, exp_done);
    check_val("t1_busy", int'(busy), 0);

    // bad checksum: writes happen, error raised, no swap
    send_frame(0, 1, 1'b0);
    exp_err++;
    check_frame("t2", 0, 0);
    check_val("t2_err", err_n, exp_err);
    check_val("t2_errcnt", int'(err_cnt), 1);
    check_val("t2_busy", int'(busy), 0);
    pulse_fs();
    check_val("t2_disp", int'(disp_buf), 1);
    check_val("t2_done", done_n, exp_done);
    send_frame(8'h30, 0, 1'b0);
    check_frame("t2b", 8'h30, 0);
    pulse_fs();
    exp_done++;
    check_val("t2b_disp", int'(disp_buf), 0);
    check_val("t2b_done", done_n, exp_done);

    // A5 A5 5A header accepted; A5 33 5A rejected
    send_byte(8'hA5, 1'b0);
    send_frame(8'h77, 0, 1'b0);
    check_frame("t3", 8'h77, 1);
    pulse_fs();
    exp_done++;
    check_val("t3_disp", int'(disp_buf), 1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (2) @(negedge clk);
    check_val("t3_nwr_bad_hdr", wq.size(), 0);
    check_val("t3_busy", int'(busy), 0);
    wq.delete();

    // partial frame then idle -> timeout
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(8'(k), 1'b0);
    check_val("t4_busy_mid", int'(busy), 1);
    repeat (TO + 10) @(negedge clk);
    exp_err++;
    check_val("t4_nwr", wq.size(), 5);
    check_val("t4_err", err_n, exp_err);
    check_val("t4_errcnt", int'(err_cnt), 2);
    check_val("t4_busy", int'(busy), 0);
    wq.delete();

    // rx_done held high yields one byte only
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    rx_byte = 8'hC3;
    rx_done = 1'b1;
    repeat (500) @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t5_nwr_hold", wq.size(), 1);
    if (wq.size() > 0) check_val("t5_wr_hold", wq[0], 8'hC3);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t5_rst_disp", int'(disp_buf), 0);
    check_val("t5_rst_wr_en", int'(wr_en), 0);
    check_val("t5_rst_busy", int'(busy), 0);
    check_val("t5_rst_errcnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    wq.delete();
    send_frame(8'h90, 0, 1'b0);
    check_frame("t5", 8'h90, 1);
    pulse_fs();
    exp_done++;
    check_val("t5_disp", int'(disp_buf), 1);
    check_val("t5_done", done_n, exp_done);

    // second frame ignored while a swap is pending
    send_frame(8'h40, 0, 1'b0);
    check_frame("t6", 8'h40, 0);
    send_frame(8'h80, 0, 1'b0);
    check_val("t6_nwr_ignored", wq.size(), 0);
    check_val("t6_busy", int'(busy), 1);
    pulse_fs();
    exp_done++;
    check_val("t6_disp", int'(disp_buf), 0);
    check_val("t6_done", done_n, exp_done);
    pulse_fs();
    check_val("t6_disp_hold", int'(disp_buf), 0);
    check_val("t6_done_hold", done_n, exp_done);

    // frame start in the same clock as the checksum pass: no swap yet
    send_frame(8'h55, 0, 1'b1);
    check_frame("t6s", 8'h55, 1);
    check_val("t6s_disp_pre", int'(disp_buf), 0);
    check_val("t6s_done_pre", done_n, exp_done);
    pulse_fs();
    exp_done++;
    check_val("t6s_disp", int'(disp_buf), 1);
    check_val("t6s_done", done_n, exp_done);

    // error counter saturation
    for (int i = 0; i < 255; i++) begin
      send_frame(i, 1, 1'b0);
      wq.delete();
    end
    exp_err += 255;
    check_val("t6_errcnt_255", int'(err_cnt), 255);
    send_frame(3, 1, 1'b0);
    wq.delete();
    exp_err++;
    check_val("t6_errcnt_sat", int'(err_cnt), 255);
    check_val("t6_err_pulses", err_n, exp_err);
    check_val("t6_disp_end", int'(disp_buf), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
